bid_auction_n: RTL and testbench

Parametrised N-bidder sealed-auction controller; the next generation of the three-bidder auction FSM in the bids22 design. A host loads balances, a mask, a bid charge and a cooldown time, then locks the block with a key and runs rounds. During a round, bidders place bids that are charged per accepted bid. At round end one cycle resolves a single winner (ties go to the lowest index) and debits the winner's balance.

---
 rtl/bid_auction_n_if.sv | 33 +++
 rtl/bid_auction_n.sv | 277 +++++++++++++++++++++++++++
 tb/tb_bid_auction_n.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bid_auction_n_if.sv
// Host and bidder signal bundle for the N-bidder sealed auction controller.
interface bid_auction_n_if #(
  parameter int NB = 4,
  parameter int DW = 32
);
  localparam int IW = $clog2(NB);

  logic [2:0]       c_op;
  logic [IW-1:0]    c_idx;
  logic [DW-1:0]    c_data;
  logic             c_start;
  logic             c_ready;
  logic [2:0]       c_err;
  logic             c_round_over;
  logic [DW-1:0]    c_max_bid;
  logic [NB-1:0]    b_bid;
  logic [NB-1:0]    b_retract;
  logic [NB*DW-1:0] b_amt;
  logic [NB-1:0]    b_ack;
  logic [NB*2-1:0]  b_err;
  logic [NB-1:0]    b_win;
  logic [NB*DW-1:0] b_balance;

  modport master (
    output c_op, c_idx, c_data, c_start, b_bid, b_retract, b_amt,
    input  c_ready, c_err, c_round_over, c_max_bid, b_ack, b_err, b_win, b_balance
  );

  modport slave (
    input  c_op, c_idx, c_data, c_start, b_bid, b_retract, b_amt,
    output c_ready, c_err, c_round_over, c_max_bid, b_ack, b_err, b_win, b_balance
  );
endinterface

// File: rtl/bid_auction_n.sv
// N-bidder sealed auction controller: host configuration, key lock with
// cooldown on a bad key, charged bidding rounds and single-winner resolve.
module bid_auction_n #(
  parameter int NB = 4,
  parameter int DW = 32,
  parameter int TW = 16
) (
  input logic            clk,
  input logic            reset_n,
  bid_auction_n_if.slave bus
);
  localparam int IW = $clog2(NB);

  localparam logic [2:0] OP_UNLOCK    = 3'd1;
  localparam logic [2:0] OP_LOCK      = 3'd2;
  localparam logic [2:0] OP_LOAD      = 3'd3;
  localparam logic [2:0] OP_SETMASK   = 3'd4;
  localparam logic [2:0] OP_SETTIMER  = 3'd5;
  localparam logic [2:0] OP_SETCHARGE = 3'd6;
  localparam logic [2:0] OP_BAD       = 3'd7;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_BADKEY   = 3'd1;
  localparam logic [2:0] E_ALREADY  = 3'd2;
  localparam logic [2:0] E_STARTUNL = 3'd3;
  localparam logic [2:0] E_INVOP    = 3'd4;
  localparam logic [2:0] E_TIE      = 3'd5;

  localparam logic [1:0] BE_NONE    = 2'd0;
  localparam logic [1:0] BE_INVALID = 2'd1;
  localparam logic [1:0] BE_INSUF   = 2'd2;

  typedef enum logic [2:0] {
    S_UNLOCKED,
    S_LOCKED,
    S_COOLDOWN,
    S_ROUND,
    S_RESOLVE,
    S_RESULT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] bal_q  [NB];
  logic [DW-1:0] last_q [NB];
  logic [NB-1:0] mask_q;
  logic [DW-1:0] charge_q;
  logic [DW-1:0] key_q;
  logic [TW-1:0] timer_q;

  logic          c_ready_q;
  logic [2:0]    c_err_q, c_err_d;
  logic          round_over_q;
  logic [DW-1:0] max_bid_q;
  logic [NB-1:0] ack_q;
  logic [NB-1:0] win_q;
  logic [2*NB-1:0] berr_q;

  logic [DW-1:0] amt [NB];
  logic [NB-1:0] bid_ok, bid_insuf, bid_inval, ret_ok;
  logic [DW-1:0] win_amt;
  logic [IW-1:0] win_idx;
  logic          win_any, win_tie;
  logic          idx_ok;

  assign idx_ok = 32'(bus.c_idx) < NB;

  // Unpack per-bidder amounts.
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      amt[i] = bus.b_amt[i*DW +: DW];
    end
  end

  // Classify each bidder's request for this cycle.
  always_comb begin
    bid_ok    = '0;
    bid_insuf = '0;
    bid_inval = '0;
    ret_ok    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (state_q != S_ROUND) begin
        bid_inval[i] = bus.b_bid[i];
      end else if (bus.c_start) begin
        if (bus.b_bid[i]) begin
          if (!mask_q[i]) begin
            bid_inval[i] = 1'b1;
          end else if (({1'b0, amt[i]} + {1'b0, charge_q}) > {1'b0, bal_q[i]}) begin
            bid_insuf[i] = 1'b1;
          end else begin
            bid_ok[i] = 1'b1;
          end
        end else if (bus.b_retract[i]) begin
          ret_ok[i] = 1'b1;
        end
      end
    end
  end

  // Highest nonzero last bid; strict compare keeps the lowest index on ties.
  always_comb begin
    win_amt = '0;
    win_idx = '0;
    win_any = 1'b0;
    win_tie = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (last_q[i] != '0) begin
        if (!win_any || last_q[i] > win_amt) begin
          win_any = 1'b1;
          win_amt = last_q[i];
          win_idx = IW'(i);
          win_tie = 1'b0;
        end else if (last_q[i] == win_amt) begin
          win_tie = 1'b1;
        end
      end
    end
  end

  // Next state, cooldown counter and host error code.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_err_d = E_NONE;
    case (state_q)
      S_UNLOCKED: begin
        if (bus.c_start) begin
          c_err_d = E_STARTUNL;
        end else begin
          case (bus.c_op)
            OP_LOCK:   state_d = S_LOCKED;
            OP_UNLOCK: c_err_d = E_ALREADY;
            OP_LOAD:   if (!idx_ok) c_err_d = E_INVOP;
            OP_BAD:    c_err_d = E_INVOP;
            default:   ;
          endcase
        end
      end
      S_LOCKED: begin
        if (bus.c_start) begin
          state_d = S_ROUND;
        end else if (bus.c_op == OP_UNLOCK) begin
          if (bus.c_data == key_q) begin
            state_d = S_UNLOCKED;
          end else begin
            state_d = S_COOLDOWN;
            cnt_d   = (timer_q == '0) ? TW'(1) : timer_q;
            c_err_d = E_BADKEY;
          end
        end
      end
      S_COOLDOWN: begin
        if (cnt_q <= TW'(1)) begin
          state_d = S_LOCKED;
        end else begin
          cnt_d   = cnt_q - TW'(1);
          c_err_d = E_BADKEY;
        end
      end
      S_ROUND: begin
        // Last bids are final here, so the tie is flagged on entry to RESOLVE.
        if (!bus.c_start) begin
          state_d = S_RESOLVE;
          if (win_tie) c_err_d = E_TIE;
        end
      end
      S_RESOLVE: state_d = S_RESULT;
      S_RESULT:  state_d = S_LOCKED;
      default:   state_d = S_UNLOCKED;
    endcase
  end

  // State register and cooldown counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Configuration, balances and last bids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NB; i++) begin
        bal_q[i]  <= '0;
        last_q[i] <= '0;
      end
      mask_q   <= '1;
      charge_q <= DW'(1);
      timer_q  <= TW'(15);
      key_q    <= '0;
    end else begin
      case (state_q)
        S_UNLOCKED: begin
          if (!bus.c_start) begin
            case (bus.c_op)
              OP_LOAD:      if (idx_ok) bal_q[bus.c_idx] <= bus.c_data;
              OP_SETMASK:   mask_q   <= bus.c_data[NB-1:0];
              OP_SETTIMER:  timer_q  <= bus.c_data[TW-1:0];
              OP_SETCHARGE: charge_q <= bus.c_data;
              OP_LOCK:      key_q    <= bus.c_data;
              default:      ;
            endcase
          end
        end
        S_LOCKED: begin
          if (bus.c_start) begin
            for (int unsigned i = 0; i < NB; i++) last_q[i] <= '0;
          end
        end
        S_ROUND: begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (bid_ok[i]) begin
              bal_q[i]  <= bal_q[i] - charge_q;
              last_q[i] <= amt[i];
            end else if (ret_ok[i]) begin
              last_q[i] <= '0;
            end
          end
        end
        S_RESOLVE: begin
          if (win_any) bal_q[win_idx] <= bal_q[win_idx] - win_amt;
        end
        default: ;
      endcase
    end
  end

  // Registered host and bidder outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_ready_q    <= 1'b1;
      c_err_q      <= E_NONE;
      round_over_q <= 1'b0;
      max_bid_q    <= '0;
      ack_q        <= '0;
      win_q        <= '0;
      berr_q       <= '0;
    end else begin
      c_ready_q    <= (state_d != S_COOLDOWN) && (state_d != S_RESOLVE);
      c_err_q      <= c_err_d;
      round_over_q <= (state_q == S_RESOLVE);
      ack_q        <= bid_ok;
      win_q        <= '0;
      if (state_q == S_RESOLVE && win_any) win_q[win_idx] <= 1'b1;
      if (state_q == S_LOCKED && bus.c_start) begin
        max_bid_q <= '0;
      end else if (state_q == S_RESOLVE) begin
        max_bid_q <= win_amt;
      end
      for (int unsigned i = 0; i < NB; i++) begin
        berr_q[2*i +: 2] <= bid_insuf[i] ? BE_INSUF :
                            bid_inval[i] ? BE_INVALID : BE_NONE;
      end
    end
  end

  // Pack balances onto the bus.
  always_comb begin
    bus.b_balance = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      bus.b_balance[i*DW +: DW] = bal_q[i];
    end
  end

  assign bus.c_ready      = c_ready_q;
  assign bus.c_err        = c_err_q;
  assign bus.c_round_over = round_over_q;
  assign bus.c_max_bid    = max_bid_q;
  assign bus.b_ack        = ack_q;
  assign bus.b_err        = berr_q;
  assign bus.b_win        = win_q;
endmodule

// File: tb/tb_bid_auction_n.sv
// Randomised and directed bench for bid_auction_n against a behavioural model.
module tb_bid_auction_n;
  localparam int NB = 4;
  localparam int DW = 32;
  localparam int TW = 16;

  localparam int P_OPEN    = 0;
  localparam int P_LOCKED  = 1;
  localparam int P_COOL    = 2;
  localparam int P_ROUND   = 3;
  localparam int P_RESOLVE = 4;
  localparam int P_RESULT  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  bid_auction_n_if #(.NB(NB), .DW(DW)) bus ();

  bid_auction_n #(.NB(NB), .DW(DW), .TW(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus
  logic [2:0]  s_op;
  logic [1:0]  s_idx;
  logic [31:0] s_data;
  logic        s_start;
  logic [3:0]  s_bid, s_ret;
  logic [31:0] s_amt [NB];

  // model state
  int          ph;
  int          m_cd;
  logic [31:0] m_bal  [NB];
  logic [31:0] m_last [NB];
  logic [3:0]  m_mask;
  logic [31:0] m_charge, m_key;
  logic [15:0] m_timer;

  // model expectations for the outputs after the next edge
  logic        e_ready, e_over;
  logic [2:0]  e_err;
  logic [31:0] e_max;
  logic [3:0]  e_ack, e_win;
  logic [1:0]  e_berr [NB];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_OPEN;
    m_cd = 0;
    for (int i = 0; i < NB; i++) begin
      m_bal[i] = '0;
      m_last[i] = '0;
      e_berr[i] = '0;
    end
    m_mask = 4'hF;
    m_charge = 32'd1;
    m_timer = 16'd15;
    m_key = '0;
    e_ready = 1'b1;
    e_over = 1'b0;
    e_err = '0;
    e_max = '0;
    e_ack = '0;
    e_win = '0;
  endtask

  // Largest nonzero last bid, how many bidders hold it, and the lowest holder.
  function automatic void find_top(output int who, output logic [31:0] top, output int n_top);
    top = '0;
    who = -1;
    n_top = 0;
    for (int i = 0; i < NB; i++) if (m_last[i] > top) top = m_last[i];
    if (top != 0) begin
      for (int i = NB - 1; i >= 0; i--) begin
        if (m_last[i] == top) begin
          who = i;
          n_top++;
        end
      end
    end
  endfunction

  task automatic model_step();
    int nxt, who, n_top;
    logic [31:0] top;
    nxt = ph;
    e_err = 3'd0;
    e_ack = '0;
    e_win = '0;
    e_over = (ph == P_RESOLVE);
    for (int i = 0; i < NB; i++) e_berr[i] = 2'd0;
    case (ph)
      P_OPEN: begin
        if (s_start) e_err = 3'd3;
        else begin
          case (s_op)
            3'd1: e_err = 3'd2;
            3'd2: begin m_key = s_data; nxt = P_LOCKED; end
            3'd3: if (int'(s_idx) < NB) m_bal[s_idx] = s_data; else e_err = 3'd4;
            3'd4: m_mask = s_data[3:0];
            3'd5: m_timer = s_data[15:0];
            3'd6: m_charge = s_data;
            3'd7: e_err = 3'd4;
            default: ;
          endcase
        end
      end
      P_LOCKED: begin
        if (s_start) begin
          nxt = P_ROUND;
          for (int i = 0; i < NB; i++) m_last[i] = '0;
          e_max = '0;
        end else if (s_op == 3'd1) begin
          if (s_data == m_key) nxt = P_OPEN;
          else begin
            m_cd = (m_timer == 0) ? 1 : int'(m_timer);
            nxt = P_COOL;
          end
        end
      end
      P_COOL: begin
        m_cd--;
        if (m_cd == 0) nxt = P_LOCKED;
      end
      P_ROUND: begin
        if (s_start) begin
          for (int i = 0; i < NB; i++) begin
            if (s_bid[i]) begin
              if (!m_mask[i]) e_berr[i] = 2'd1;
              else if ({32'd0, s_amt[i]} + {32'd0, m_charge} > {32'd0, m_bal[i]}) e_berr[i] = 2'd2;
              else begin
                m_bal[i] = m_bal[i] - m_charge;
                m_last[i] = s_amt[i];
                e_ack[i] = 1'b1;
              end
            end else if (s_ret[i]) begin
              m_last[i] = '0;
            end
          end
        end else begin
          find_top(who, top, n_top);
          if (n_top > 1) e_err = 3'd5;
          nxt = P_RESOLVE;
        end
      end
      P_RESOLVE: begin
        find_top(who, top, n_top);
        if (who >= 0) begin
          m_bal[who] = m_bal[who] - top;
          e_win[who] = 1'b1;
        end
        e_max = top;
        nxt = P_RESULT;
      end
      default: nxt = P_LOCKED;
    endcase
    if (ph != P_ROUND) begin
      for (int i = 0; i < NB; i++) if (s_bid[i]) e_berr[i] = 2'd1;
    end
    ph = nxt;
    e_ready = !(ph == P_COOL || ph == P_RESOLVE);
    if (ph == P_COOL) e_err = 3'd1;
  endtask

  task automatic compare_all();
    check("ready", 64'(bus.c_ready), 64'(e_ready));
    check("err", 64'(bus.c_err), 64'(e_err));
    check("over", 64'(bus.c_round_over), 64'(e_over));
    check("max", 64'(bus.c_max_bid), 64'(e_max));
    check("ack", 64'(bus.b_ack), 64'(e_ack));
    check("win", 64'(bus.b_win), 64'(e_win));
    for (int i = 0; i < NB; i++) begin
      check($sformatf("berr%0d", i), 64'(bus.b_err[2*i +: 2]), 64'(e_berr[i]));
      check($sformatf("bal%0d", i), 64'(bus.b_balance[32*i +: 32]), 64'(m_bal[i]));
    end
  endtask

  task automatic cycle();
    bus.c_op = s_op;
    bus.c_idx = s_idx;
    bus.c_data = s_data;
    bus.c_start = s_start;
    bus.b_bid = s_bid;
    bus.b_retract = s_ret;
    for (int i = 0; i < NB; i++) bus.b_amt[32*i +: 32] = s_amt[i];
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    s_op = '0;
    s_idx = '0;
    s_data = '0;
    s_bid = '0;
    s_ret = '0;
    for (int i = 0; i < NB; i++) s_amt[i] = '0;
  endtask

  task automatic tick();
    idle_inputs();
    cycle();
  endtask

  task automatic host(input logic [2:0] op, input logic [31:0] d, input logic [1:0] i);
    idle_inputs();
    s_op = op;
    s_data = d;
    s_idx = i;
    cycle();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int bk;
    idle_inputs();
    s_start = 1'b0;
    bus.c_op = '0; bus.c_idx = '0; bus.c_data = '0; bus.c_start = 1'b0;
    bus.b_bid = '0; bus.b_retract = '0; bus.b_amt = '0;
    #2;
    apply_reset();

    // configuration and a plain round
    for (int i = 0; i < NB; i++) host(3'd3, 32'd100, 2'(i));
    host(3'd6, 32'd2, 2'd0);
    host(3'd2, 32'hA5, 2'd0);
    s_start = 1'b1;
    tick();
    idle_inputs();
    s_bid = 4'b0110; s_amt[1] = 32'd40; s_amt[2] = 32'd30;
    cycle();
    check("plan_ack", 64'(bus.b_ack), 64'h6);
    check("plan_bal1_charged", 64'(bus.b_balance[63:32]), 64'd98);
    check("plan_bal2_charged", 64'(bus.b_balance[95:64]), 64'd98);
    s_start = 1'b0;
    tick();
    tick();
    check("plan_win", 64'(bus.b_win), 64'h2);
    check("plan_max", 64'(bus.c_max_bid), 64'd40);
    check("plan_bal1_debit", 64'(bus.b_balance[63:32]), 64'd58);
    tick();

    // tie between bidders 0 and 3
    s_start = 1'b1;
    tick();
    idle_inputs();
    s_bid = 4'b1001; s_amt[0] = 32'd50; s_amt[3] = 32'd50;
    cycle();
    s_start = 1'b0;
    tick();
    check("tie_err", 64'(bus.c_err), 64'd5);
    tick();
    check("tie_win", 64'(bus.b_win), 64'h1);
    check("tie_bal0", 64'(bus.b_balance[31:0]), 64'd48);
    tick();

    // insufficient funds, then masked bidder
    host(3'd1, 32'hA5, 2'd0);
    host(3'd3, 32'd10, 2'd0);
    host(3'd6, 32'd1, 2'd0);
    host(3'd2, 32'h11, 2'd0);
    s_start = 1'b1;
    tick();
    idle_inputs();
    s_bid = 4'b0001; s_amt[0] = 32'd10;
    cycle();
    check("funds_err", 64'(bus.b_err[1:0]), 64'd2);
    check("funds_nodebit", 64'(bus.b_balance[31:0]), 64'd10);
    s_start = 1'b0;
    tick(); tick(); tick();
    host(3'd1, 32'h11, 2'd0);
    host(3'd4, 32'hE, 2'd0);
    host(3'd2, 32'h11, 2'd0);
    s_start = 1'b1;
    tick();
    idle_inputs();
    s_bid = 4'b0001; s_amt[0] = 32'd5;
    cycle();
    check("mask_err", 64'(bus.b_err[1:0]), 64'd1);
    s_start = 1'b0;
    tick(); tick(); tick();

    // bad key and cooldown length
    host(3'd1, 32'h11, 2'd0);
    host(3'd5, 32'd5, 2'd0);
    host(3'd2, 32'd7, 2'd0);
    host(3'd1, 32'd8, 2'd0);
    bk = (bus.c_err == 3'd1) ? 1 : 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.c_err == 3'd1) bk++;
    end
    check("badkey_cycles", 64'(bk), 64'd5);
    check("badkey_ready", 64'(bus.c_ready), 64'd1);
    host(3'd1, 32'd7, 2'd0);
    host(3'd1, 32'd0, 2'd0);
    check("unlocked_again", 64'(bus.c_err), 64'd2);

    // retract leaves no winner
    host(3'd4, 32'hF, 2'd0);
    host(3'd3, 32'd100, 2'd0);
    host(3'd2, 32'd3, 2'd0);
    s_start = 1'b1;
    tick();
    idle_inputs();
    s_bid = 4'b0001; s_amt[0] = 32'd60;
    cycle();
    idle_inputs();
    s_ret = 4'b0001;
    cycle();
    s_start = 1'b0;
    tick();
    tick();
    check("retract_over", 64'(bus.c_round_over), 64'd1);
    check("retract_win", 64'(bus.b_win), 64'd0);
    check("retract_max", 64'(bus.c_max_bid), 64'd0);
    tick();

    // reset in the middle of a round
    s_start = 1'b1;
    tick();
    idle_inputs();
    s_bid = 4'b0010; s_amt[1] = 32'd10;
    cycle();
    s_start = 1'b0;
    idle_inputs();
    apply_reset();
    check("reset_bal1", 64'(bus.b_balance[63:32]), 64'd0);
    host(3'd1, 32'd0, 2'd0);
    check("reset_unlocked", 64'(bus.c_err), 64'd2);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      if ($urandom_range(0, 7) == 0) s_start = ~s_start;
      if ($urandom_range(0, 1) == 1) begin
        s_op = 3'($urandom_range(1, 7));
        s_idx = 2'($urandom_range(0, 3));
        case (s_op)
          3'd3:    s_data = $urandom_range(0, 200);
          3'd4:    s_data = $urandom_range(0, 15);
          3'd5:    s_data = $urandom_range(0, 6);
          default: s_data = $urandom_range(0, 3);
        endcase
      end
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 3) == 0) s_bid[i] = 1'b1;
        if ($urandom_range(0, 7) == 0) s_ret[i] = 1'b1;
        s_amt[i] = $urandom_range(0, 80);
      end
      cycle();
      if ($urandom_range(0, 599) == 0) begin
        s_start = 1'b0;
        idle_inputs();
        apply_reset();
      end
    end

    s_start = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
